// File: rtl/bf_pkg.sv
// Shared definitions for the beamformer SPI output stage.
//  - bf_spi_state_e : serialiser FSM states
//  - frame_bits()   : SPI frame length from address/data field widths
//  - BF_CLK_DIV / BF_CS_GAP : default SPI timing used by the beamformer top
package bf_pkg;

  localparam int BF_CLK_DIV = 4;  // clk cycles per SCLK half-period
  localparam int BF_CS_GAP  = 2;  // clk cycles of cs_n high between frames

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_LOAD  = 3'd5
  } bf_spi_state_e;

  function automatic int frame_bits(input int addr_bits, input int data_bits);
    return addr_bits + data_bits;
  endfunction

endpackage

// File: rtl/bf_sync_fifo.sv
// Synchronous FIFO with a registered first-word output (first-word fall-through).
// The head entry is moved from the RAM into rd_data one cycle after it becomes
// available; rd_valid flags that rd_data holds the head. pop consumes it.
// Ports:
//  clk, rst_n : clock, async active-low reset
//  wr_en      : write request; ignored while full
//  wr_data    : entry to store
//  pop        : consume rd_data (only honoured while rd_valid)
//  rd_data    : head entry (registered)
//  rd_valid   : rd_data holds a valid entry
//  full       : occupancy == DEPTH (registered)
//  level      : total occupancy, RAM plus output register (registered)
module bf_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             take;
  logic             ram_empty;
  logic             load;
  logic [LW-1:0]    level_next;

  assign push      = wr_en && !full;
  assign take      = pop && rd_valid;
  assign ram_empty = (wr_ptr == rd_ptr);
  // Refill the output register whenever it is empty or being consumed.
  assign load      = !ram_empty && (!rd_valid || take);

  always_comb begin
    level_next = level;
    case ({push, take})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Storage and registered read; no reset so the array maps onto RAM.
  // Total occupancy never exceeds DEPTH, so the write slot can never be the
  // slot being read in the same cycle.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
    if (load) begin
      rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      level    <= '0;
      full     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr   <= rd_ptr + 1'b1;
        rd_valid <= 1'b1;
      end else if (take) begin
        rd_valid <= 1'b0;
      end
      level <= level_next;
      full  <= (level_next == LW'(DEPTH));
    end
  end

endmodule

// File: rtl/bf_spi_channel_tx.sv
// Per-channel SPI output stage of the beamformer. Buffers {addr,data} words
// from one calc unit, sends each as one mode-0 SPI frame (low address bits then
// low data bits, MSB first) and pulses spi_ld once the FIFO has drained.
// Ports:
//  clk, rst_n : clock, async active-low reset
//  en         : 1 = start new frames; 0 = finish current frame then idle
//  wr_en      : write strobe; wr_addr / wr_data : register address / data
//  full       : FIFO full (writes dropped); level : FIFO occupancy
//  overflow   : sticky dropped-write flag; clr_err clears it (clear wins)
//  busy       : FSM active or FIFO not empty
//  spi_sclk, spi_cs_n, spi_mosi : SPI bus
//  spi_ld     : latch pulse after a batch; batch_done : pulse on its last cycle
module bf_spi_channel_tx
  import bf_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int SPI_ADDR_BITS = 8,
  parameter int SPI_DATA_BITS = 16,
  parameter int CLK_DIV       = BF_CLK_DIV,
  parameter int CS_GAP        = BF_CS_GAP
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  input  logic                        clr_err,
  output logic                        busy,
  output logic                        spi_sclk,
  output logic                        spi_cs_n,
  output logic                        spi_mosi,
  output logic                        spi_ld,
  output logic                        batch_done
);

  localparam int FRAME_BITS = frame_bits(SPI_ADDR_BITS, SPI_DATA_BITS);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS);

  bf_spi_state_e         state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] fifo_wr_data;
  logic [FRAME_BITS-1:0] fifo_rd_data;
  logic                  fifo_rd_valid;
  logic                  pop;
  logic [DW-1:0]         div_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  div_last;
  logic                  gap_last;
  logic                  ld_half;
  logic                  ld_last_next;
  logic                  pending_ld;
  logic                  unused_bits;

  assign fifo_wr_data = {wr_addr[SPI_ADDR_BITS-1:0], wr_data[SPI_DATA_BITS-1:0]};
  // Upper address/data bits are not transmitted on this bus.
  assign unused_bits  = ^{wr_addr, wr_data};

  assign div_last = (div_cnt == DIV_LAST);
  assign gap_last = (gap_cnt == GAP_LAST);

  // A frame starts from IDLE, or straight from the end of GAP for back-to-back
  // frames. The pop and the shift-register load happen on the same edge.
  assign pop = en && fifo_rd_valid &&
               ((state == ST_IDLE) || ((state == ST_GAP) && gap_last));

  // LOAD runs for two divider periods (ld_half selects the second); this is
  // high when the cycle after the current one is the final spi_ld cycle.
  assign ld_last_next = div_last ? (!ld_half && (CLK_DIV == 1))
                                 : (ld_half && ((div_cnt + 1'b1) == DIV_LAST));

  bf_sync_fifo #(
    .WIDTH (FRAME_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (fifo_wr_data),
    .pop      (pop),
    .rd_data  (fifo_rd_data),
    .rd_valid (fifo_rd_valid),
    .full     (full),
    .level    (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clr_err) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (state != ST_IDLE) || (level != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      ld_half    <= 1'b0;
      pending_ld <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_ld     <= 1'b0;
      batch_done <= 1'b0;
    end else begin
      batch_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            state     <= ST_SETUP;
            shift_reg <= fifo_rd_data;
            spi_mosi  <= fifo_rd_data[FRAME_BITS-1];
            spi_cs_n  <= 1'b0;
            spi_sclk  <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
          end else if (pending_ld && (level == '0)) begin
            // Latch only once the whole batch has been shifted out.
            state   <= ST_LOAD;
            spi_ld  <= 1'b1;
            div_cnt <= '0;
            ld_half <= 1'b0;
          end
        end

        ST_SETUP: begin
          if (div_last) begin
            state    <= ST_SHIFT;
            spi_sclk <= 1'b1;
            div_cnt  <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (spi_sclk) begin
              // Falling edge: bit done, present the next one.
              spi_sclk  <= 1'b0;
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
              spi_mosi  <= shift_reg[FRAME_BITS-2];
            end else if (bit_cnt == BIT_LAST) begin
              // Low half-period after the final fall has elapsed.
              state <= ST_HOLD;
            end else begin
              spi_sclk <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        ST_HOLD: begin
          if (div_last) begin
            state      <= ST_GAP;
            spi_cs_n   <= 1'b1;
            gap_cnt    <= '0;
            div_cnt    <= '0;
            pending_ld <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        ST_GAP: begin
          if (gap_last) begin
            if (pop) begin
              state     <= ST_SETUP;
              shift_reg <= fifo_rd_data;
              spi_mosi  <= fifo_rd_data[FRAME_BITS-1];
              spi_cs_n  <= 1'b0;
              spi_sclk  <= 1'b0;
              div_cnt   <= '0;
              bit_cnt   <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        ST_LOAD: begin
          if (ld_last_next) begin
            batch_done <= 1'b1;
          end
          if (div_last) begin
            div_cnt <= '0;
            if (ld_half) begin
              state      <= ST_IDLE;
              spi_ld     <= 1'b0;
              pending_ld <= 1'b0;
              ld_half    <= 1'b0;
            end else begin
              ld_half <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_spi_channel_tx.sv
module tb_bf_spi_channel_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        clr_err;
  logic        full;
  logic [4:0]  level;
  logic        overflow;
  logic        busy;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_ld;
  logic        batch_done;

  int total = 0;
  int bad = 0;

  // scoreboard: expected frames, pushed at write time
  logic [23:0] exp_q[$];
  int          gap_q[$];

  // monitor state
  logic        in_frame = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_ld = 1'b0;
  logic [23:0] sh = '0;
  logic [23:0] e_frame;
  int          mon_edges = 0;
  int          frames_seen = 0;
  int          ld_count = 0;
  int          bd_count = 0;
  int          ld_len = 0;
  int          hi_cnt = 0;

  // bench temporaries
  int f0, l0, b0, n, ng;

  always #5 clk = ~clk;

  bf_spi_channel_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .full       (full),
    .level      (level),
    .overflow   (overflow),
    .clr_err    (clr_err),
    .busy       (busy),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_ld     (spi_ld),
    .batch_done (batch_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit accept);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    if (accept) exp_q.push_back({a[7:0], d[15:0]});
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_ld(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (ld_count < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, ld_count >= target, 1);
  endtask

  // SPI monitor: reassembles frames and measures cs_n gaps and spi_ld width
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame  = 1'b0;
      mon_edges = 0;
      ld_len    = 0;
    end else begin
      if (spi_cs_n) hi_cnt++;
      if (prev_cs && !spi_cs_n) begin
        gap_q.push_back(hi_cnt);
        hi_cnt    = 0;
        in_frame  = 1'b1;
        mon_edges = 0;
        sh        = '0;
      end
      if (in_frame && !prev_sclk && spi_sclk) begin
        sh = {sh[22:0], spi_mosi};
        mon_edges++;
      end
      if (in_frame && !prev_cs && spi_cs_n) begin
        in_frame = 1'b0;
        frames_seen++;
        check("frame_rising_edges", mon_edges, 24);
        if (exp_q.size() == 0) begin
          check("frame_unexpected", exp_q.size(), 1);
        end else begin
          e_frame = exp_q.pop_front();
          $display("frame %0d: mosi=0x%06h expected=0x%06h", frames_seen, sh, e_frame);
          check("frame_data", sh, e_frame);
        end
      end
      if (spi_ld) ld_len++;
      if (batch_done) begin
        bd_count++;
        check("ld_len_at_batch_done", ld_len, 8);
      end
      if (prev_ld && !spi_ld) begin
        ld_count++;
        ld_len = 0;
      end
    end
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
    prev_ld   = spi_ld;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_ld", spi_ld, 0);
    check("rst_batch_done", batch_done, 0);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single word: truncation, latency, ld width
    en = 1'b1;
    f0 = frames_seen; l0 = ld_count; b0 = bd_count;
    wr(32'hFFFF_FF12, 32'h5555_ABCD, 1'b1);
    check("t1_level_after_write", level, 1);
    check("t1_cs_n_cycle1", spi_cs_n, 1);
    @(negedge clk);
    check("t1_cs_n_cycle2", spi_cs_n, 1);
    @(negedge clk);
    check("t1_cs_n_cycle3", spi_cs_n, 0);
    wait_ld(l0 + 1, 400, "t1_ld_timeout");
    repeat (2) @(negedge clk);
    check("t1_frames", frames_seen - f0, 1);
    check("t1_batch_done", bd_count - b0, 1);
    check("t1_busy_idle", busy, 0);

    // fill to full with en=0, overflow and clear behaviour
    en = 1'b0;
    for (int i = 0; i < 16; i++) wr($urandom, $urandom, 1'b1);
    check("t2_full", full, 1);
    check("t2_level16", level, 16);
    check("t2_no_overflow_yet", overflow, 0);
    check("t2_busy_full", busy, 1);
    wr(32'h0000_00EE, 32'h0000_EEEE, 1'b0);
    check("t2_overflow_set", overflow, 1);
    check("t2_level_after_drop", level, 16);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t2_overflow_cleared", overflow, 0);
    clr_err = 1'b1;
    wr(32'h0000_00EF, 32'h0000_EFEF, 1'b0);
    clr_err = 1'b0;
    check("t2_clr_wins", overflow, 0);
    wr(32'h0000_00F0, 32'h0000_F0F0, 1'b0);
    check("t2_overflow_reset_again", overflow, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t2_overflow_cleared2", overflow, 0);
    gap_q.delete();
    f0 = frames_seen; l0 = ld_count;
    en = 1'b1;
    wait_ld(l0 + 1, 4000, "t2_ld_timeout");
    repeat (2) @(negedge clk);
    check("t2_frames16", frames_seen - f0, 16);
    check("t2_one_ld", ld_count - l0, 1);
    check("t2_gap_entries", gap_q.size(), 16);
    ng = 0;
    for (int i = 1; i < gap_q.size(); i++) if (gap_q[i] != 2) ng++;
    check("t2_gaps_not_2", ng, 0);
    check("t2_sb_empty", exp_q.size(), 0);
    check("t2_level0", level, 0);
    check("t2_full0", full, 0);

    // write during SHIFT of frame 1
    gap_q.delete();
    f0 = frames_seen; l0 = ld_count;
    wr(32'h0000_0033, 32'h0000_1234, 1'b1);
    repeat (60) @(negedge clk);
    check("t3_in_frame", spi_cs_n, 0);
    wr(32'h0000_00C5, 32'h0000_8001, 1'b1);
    wait_ld(l0 + 1, 800, "t3_ld_timeout");
    repeat (2) @(negedge clk);
    check("t3_frames2", frames_seen - f0, 2);
    check("t3_one_ld", ld_count - l0, 1);
    check("t3_gap_entries", gap_q.size(), 2);
    if (gap_q.size() == 2) check("t3_gap2", gap_q[1], 2);

    // en drop at bit 10 with 3 words queued
    f0 = frames_seen; l0 = ld_count;
    for (int i = 0; i < 3; i++) wr($urandom, $urandom, 1'b1);
    n = 0;
    while (!(in_frame && mon_edges >= 10) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t4_reach_bit10", n < 300, 1);
    en = 1'b0;
    n = 0;
    while (frames_seen < f0 + 1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t4_frame_done", n < 400, 1);
    repeat (40) @(negedge clk);
    check("t4_level2", level, 2);
    check("t4_no_ld", ld_count - l0, 0);
    check("t4_one_frame", frames_seen - f0, 1);
    check("t4_cs_high", spi_cs_n, 1);
    check("t4_busy", busy, 1);
    en = 1'b1;
    wait_ld(l0 + 1, 1000, "t4_ld_timeout");
    repeat (2) @(negedge clk);
    check("t4_frames3", frames_seen - f0, 3);
    check("t4_level0", level, 0);

    // async reset mid-SHIFT
    for (int i = 0; i < 2; i++) wr($urandom, $urandom, 1'b1);
    n = 0;
    while (!(in_frame && mon_edges >= 5) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_shift", n < 300, 1);
    f0 = frames_seen; l0 = ld_count; b0 = bd_count;
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_cs_n", spi_cs_n, 1);
    check("t5_async_sclk", spi_sclk, 0);
    check("t5_async_level", level, 0);
    check("t5_async_ld", spi_ld, 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("t5_no_frames", frames_seen - f0, 0);
    check("t5_no_ld", ld_count - l0, 0);
    check("t5_no_batch_done", bd_count - b0, 0);
    check("t5_busy", busy, 0);

    // recovery after reset
    f0 = frames_seen; l0 = ld_count;
    wr(32'h0000_005A, 32'h0000_C3C3, 1'b1);
    wait_ld(l0 + 1, 400, "t6_ld_timeout");
    check("t6_frames1", frames_seen - f0, 1);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
